// File: rtl/reaction_round_ctrl_if.sv
// Bus bundle for the reaction-round session sequencer.
// Handshake: rand_req is high for exactly one cycle, the cycle the
// sequencer spends arming a trial. rand_num must already be valid and stable
// during that cycle. It is captured on the clock edge that ends the cycle,
// and no acknowledge is returned. All other inputs are single-cycle strobes
// with no back-pressure.
interface reaction_round_ctrl_if #(
    parameter int TIME_W = 16,
    parameter int RAND_W = 13
);
    logic              start;
    logic              act;
    logic              tick;
    logic [RAND_W-1:0] rand_num;
    logic              rand_req;
    logic              lamp;
    logic              busy;
    logic [2:0]        round_idx;
    logic [TIME_W-1:0] last_time;
    logic [TIME_W-1:0] best_time;
    logic [TIME_W-1:0] avg_time;
    logic              result_valid;
    logic              false_start;
    logic              timed_out;
    logic              done;
    logic [2:0]        state_dbg;

    modport master (
        output start, act, tick, rand_num,
        input  rand_req, lamp, busy, round_idx, last_time, best_time, avg_time,
        input  result_valid, false_start, timed_out, done, state_dbg
    );

    modport slave (
        input  start, act, tick, rand_num,
        output rand_req, lamp, busy, round_idx, last_time, best_time, avg_time,
        output result_valid, false_start, timed_out, done, state_dbg
    );
endinterface

// File: rtl/reaction_round_ctrl.sv
// Session sequencer for the reaction-time tester: runs ROUNDS trials per
// start press, handles false starts and timeouts, and keeps the last, best
// and average reaction times. The interface TIME_W/RAND_W must match the
// parameters given here.
module reaction_round_ctrl #(
    parameter int ROUNDS    = 4,
    parameter int TIME_W    = 16,
    parameter int RAND_W    = 13,
    parameter int MIN_DELAY = 500,
    parameter int TIMEOUT   = 2000
) (
    input logic                  clk,
    input logic                  rst,
    reaction_round_ctrl_if.slave bus
);
    localparam int DLY_W  = RAND_W + 1;
    localparam int SUM_W  = TIME_W + 3;
    localparam int LOG2_R = $clog2(ROUNDS);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ARM    = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_GO     = 3'd3;
    localparam logic [2:0] S_RECORD = 3'd4;
    localparam logic [2:0] S_FAULT  = 3'd5;
    localparam logic [2:0] S_NEXT   = 3'd6;
    localparam logic [2:0] S_DONE   = 3'd7;

    logic [2:0]        state_q,        state_d;
    logic [DLY_W-1:0]  delay_cnt_q,    delay_cnt_d;
    logic [TIME_W-1:0] react_cnt_q,    react_cnt_d;
    logic [TIME_W-1:0] rec_val_q,      rec_val_d;
    logic [2:0]        round_idx_q,    round_idx_d;
    logic [SUM_W-1:0]  sum_q,          sum_d;
    logic [TIME_W-1:0] last_time_q,    last_time_d;
    logic [TIME_W-1:0] best_time_q,    best_time_d;
    logic [TIME_W-1:0] avg_time_q,     avg_time_d;
    logic              result_valid_q, result_valid_d;
    logic              timed_out_q,    timed_out_d;

    // Next-state and datapath: one case arm per state, everything registered.
    always_comb begin
        state_d        = state_q;
        delay_cnt_d    = delay_cnt_q;
        react_cnt_d    = react_cnt_q;
        rec_val_d      = rec_val_q;
        round_idx_d    = round_idx_q;
        sum_d          = sum_q;
        last_time_d    = last_time_q;
        best_time_d    = best_time_q;
        avg_time_d     = avg_time_q;
        result_valid_d = 1'b0;
        timed_out_d    = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                // A new session wipes the statistics and starts at round 0.
                if (bus.start) begin
                    sum_d       = '0;
                    best_time_d = '1;
                    last_time_d = '0;
                    avg_time_d  = '0;
                    round_idx_d = '0;
                    state_d     = S_ARM;
                end
            end
            S_ARM: begin
                delay_cnt_d = DLY_W'(bus.rand_num) + DLY_W'(MIN_DELAY);
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                // act wins even against the tick that would light the lamp.
                if (bus.act) begin
                    state_d = S_FAULT;
                end else if (bus.tick) begin
                    delay_cnt_d = delay_cnt_q - DLY_W'(1);
                    if (delay_cnt_q == DLY_W'(1)) begin
                        react_cnt_d = '0;
                        state_d     = S_GO;
                    end
                end
            end
            S_GO: begin
                // On act+tick the pre-increment count is the reaction time.
                if (bus.act) begin
                    rec_val_d = react_cnt_q;
                    state_d   = S_RECORD;
                end else if (bus.tick) begin
                    if (react_cnt_q == TIME_W'(TIMEOUT - 1)) begin
                        rec_val_d   = TIME_W'(TIMEOUT);
                        timed_out_d = 1'b1;
                        state_d     = S_RECORD;
                    end else begin
                        react_cnt_d = react_cnt_q + TIME_W'(1);
                    end
                end
            end
            S_RECORD: begin
                last_time_d    = rec_val_q;
                result_valid_d = 1'b1;
                if (rec_val_q < best_time_q) begin
                    best_time_d = rec_val_q;
                end
                sum_d   = sum_q + SUM_W'(rec_val_q);
                state_d = S_NEXT;
            end
            S_NEXT: begin
                if (round_idx_q == 3'(ROUNDS - 1)) begin
                    avg_time_d = TIME_W'(sum_q >> LOG2_R);
                    state_d    = S_DONE;
                end else begin
                    round_idx_d = round_idx_q + 3'd1;
                    state_d     = S_ARM;
                end
            end
            S_FAULT: begin
                // Retry the same round; nothing recorded for the aborted trial.
                if (bus.start) begin
                    state_d = S_ARM;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            delay_cnt_q    <= '0;
            react_cnt_q    <= '0;
            rec_val_q      <= '0;
            round_idx_q    <= '0;
            sum_q          <= '0;
            last_time_q    <= '0;
            best_time_q    <= '1;
            avg_time_q     <= '0;
            result_valid_q <= 1'b0;
            timed_out_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            delay_cnt_q    <= delay_cnt_d;
            react_cnt_q    <= react_cnt_d;
            rec_val_q      <= rec_val_d;
            round_idx_q    <= round_idx_d;
            sum_q          <= sum_d;
            last_time_q    <= last_time_d;
            best_time_q    <= best_time_d;
            avg_time_q     <= avg_time_d;
            result_valid_q <= result_valid_d;
            timed_out_q    <= timed_out_d;
        end
    end

    // Status outputs decode directly from the registered state, so lamp
    // drops as soon as reset clears the state register.
    assign bus.rand_req     = (state_q == S_ARM);
    assign bus.lamp         = (state_q == S_GO);
    assign bus.busy         = (state_q != S_IDLE) && (state_q != S_DONE);
    assign bus.false_start  = (state_q == S_FAULT);
    assign bus.done         = (state_q == S_DONE);
    assign bus.round_idx    = round_idx_q;
    assign bus.last_time    = last_time_q;
    assign bus.best_time    = best_time_q;
    assign bus.avg_time     = avg_time_q;
    assign bus.result_valid = result_valid_q;
    assign bus.timed_out    = timed_out_q;
    assign bus.state_dbg    = state_q;
endmodule
